siso_llr_buf_ctrl: RTL and testbench
====================================

Name: siso_llr_buf_ctrl

Overview:
- Sequencer for the 16-bit x 6147-entry single-port LLR block RAM used by the SISO decoder.
- Capture phase: streams one code block of LLRs (up to K = 6144 plus 3 tail samples) into the RAM.
- Replay phase: reads the block back as a stream, in forward or reverse order (reverse feeds the backward/beta recursion).
- Owns every RAM port; sits between the LLR input stream and the SISO recursion units.

Parameters:
- ADDR_W, 13, RAM address width.
- DATA_W, 16, LLR sample width.
- MAX_LEN, 6147, largest legal block length in samples (6144 + 3 tail).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a block; sampled only in IDLE.
- blk_len  in  ADDR_W  block length in samples; latched on accepted start.
- rev  in  1  replay order, latched on accepted start: 0 = address 0 upward, 1 = blk_len-1 downward.
- s_valid  in  1  input sample valid.
- s_data  in  DATA_W  input LLR sample.
- s_ready  out  1  controller accepts an input sample.
- m_valid  out  1  replay sample valid.
- m_data  out  DATA_W  replay LLR sample.
- m_last  out  1  marks the final replay sample; qualified by m_valid.
- m_ready  in  1  downstream accepts the replay sample.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_di  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM read data; registered, one-cycle latency, read-first.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final replay handshake.
- err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset values:
  - s_ready, m_valid, m_last, ram_we, busy, done, err = 0.
  - ram_addr, ram_di, m_data = 0.
  - State = IDLE.
  - RAM contents are not cleared.
- States: IDLE, WRITE, READ, FLUSH.
- IDLE:
  - start=1 with 1 <= blk_len <= MAX_LEN: latch blk_len and rev, clear counters, go to WRITE next cycle.
  - start=1 with blk_len = 0 or blk_len > MAX_LEN: err pulses next cycle; stay in IDLE.
- WRITE:
  - s_ready=1 throughout WRITE.
  - On each s_valid&&s_ready: ram_we=1, ram_addr=wr_cnt, ram_di=s_data, wr_cnt+1; all combinational in the same cycle.
  - s_valid=0: ram_we=0 and wr_cnt holds.
  - Handshake writing address blk_len-1: go to READ next cycle; s_ready=0 from that cycle on.
- READ:
  - Issues read addresses: rev=0 gives 0..blk_len-1; rev=1 gives blk_len-1..0. ram_we=0.
  - Each read data is presented one cycle after its address (RAM latency).
  - Flow-control contract:
    - m_data and m_last are stable while m_valid&&!m_ready.
    - No sample is lost or duplicated under any m_ready pattern.
    - Sustained throughput is 1 sample/cycle when m_ready=1.
    - First m_valid appears 2 cycles after entering READ, i.e. address issued, then data registered into the output register.
  - A one-entry skid register is required. On a stall it holds the in-flight ram_dout; address issue stops until the skid drains.
  - m_last=1 with the sample read from the final address (address 0 when rev=1).
- FLUSH:
  - Entered once the final address has been issued.
  - Waits for the remaining samples to be handshaken.
  - On the m_last handshake: done=1 the next cycle and return to IDLE in that same cycle.
- start while busy is ignored; no err.
- blk_len=1: one write, one replay sample with m_last=1; rev has no effect.
- Counters never wrap: addresses stay within 0..blk_len-1.
- rst asserted mid-block: next cycle is IDLE with all outputs at reset values; partially written data is abandoned.
- Throughput: a block of N samples at full rate takes N write cycles, plus N + 2 replay cycles, plus 1 done cycle.

Test Plan:
- Forward basic: start, blk_len=8, rev=0, write samples 0x0010..0x0017 back-to-back, m_ready=1 -> m_data 0x0010..0x0017 on consecutive cycles; m_last on 0x0017; done 1 cycle after; busy falls with done.
- Reverse max length: blk_len=6147, rev=1, ramp data k -> replay 6146 down to 0; m_last on 0; no ram_addr > 6146; exactly 6147 m_valid&&m_ready handshakes.
- Backpressure: blk_len=16, rev=1, m_ready toggled in a pseudo-random pattern (e.g. 1101 0010 repeating) -> output sequence identical to the m_ready=1 case; m_data stable during each stall.
- Bad length: start with blk_len=0, then with blk_len=6148 -> one err pulse each, busy stays 0, no ram_we; a following start with blk_len=4 runs normally.
- Gapped input plus ignored start: blk_len=5, s_valid in bursts with idle cycles, extra start pulse during WRITE -> only 5 writes at addresses 0..4; extra start has no effect.
- Reset mid-READ: rst for 1 cycle after the 3rd replay sample of blk_len=10 -> next cycle all outputs 0 and state IDLE; a new block then starts cleanly.

Source files
------------

// File: rtl/siso_llr_buf_ctrl.sv
// siso_llr_buf_ctrl: capture/replay sequencer for the single-port SISO LLR block RAM
//   clk, rst                  clock, synchronous active-high reset
//   start, blk_len, rev       block request; length and replay order latched on accepted start
//   s_valid, s_data, s_ready  LLR capture stream
//   m_valid, m_data, m_last,  LLR replay stream (forward or reverse order)
//   m_ready
//   ram_we, ram_addr, ram_di, RAM port; ram_dout is registered, one-cycle latency, read-first
//   ram_dout
//   busy, done, err           not-idle flag, end-of-block pulse, rejected-start pulse
module siso_llr_buf_ctrl #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 16,
    parameter int MAX_LEN = 6147
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] blk_len,
    input  logic              rev,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;
    localparam logic [ADDR_W-1:0] MAX_L = ADDR_W'(MAX_LEN);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d, wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic              rev_q, rev_d;
    logic              pend_q, pend_d, pend_last_q, pend_last_d;
    logic              m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              sk_valid_q, sk_valid_d, sk_last_q, sk_last_d;
    logic [DATA_W-1:0] sk_data_q, sk_data_d;
    logic              done_q, done_d, err_q, err_d;
    logic              out_free, issue, last_addr;
    logic [ADDR_W-1:0] rd_addr;

    // Output register plus skid. pend_q marks that ram_dout carries a sample this
    // cycle; reads are only issued when the skid will be empty, so pend_q and
    // sk_valid_q are never both set and the in-flight sample always has a home.
    always_comb begin
        out_free   = !m_valid_q || m_ready;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;
        sk_valid_d = sk_valid_q;
        sk_data_d  = sk_data_q;
        sk_last_d  = sk_last_q;
        if (out_free) begin
            m_valid_d  = sk_valid_q || pend_q;
            m_data_d   = sk_valid_q ? sk_data_q : pend_q ? ram_dout : m_data_q;
            m_last_d   = sk_valid_q ? sk_last_q : pend_q && pend_last_q;
            sk_valid_d = 1'b0;
        end else if (pend_q) begin
            sk_valid_d = 1'b1;
            sk_data_d  = ram_dout;
            sk_last_d  = pend_last_q;
        end
    end

    always_comb begin
        s_ready     = state_q == WRITE;
        ram_we      = s_ready && s_valid;
        issue       = state_q == READ && !sk_valid_d;
        last_addr   = rd_cnt_q == len_q - 1'b1;
        rd_addr     = rev_q ? len_q - 1'b1 - rd_cnt_q : rd_cnt_q;
        ram_addr    = ram_we ? wr_cnt_q : issue ? rd_addr : '0;
        ram_di      = ram_we ? s_data : '0;
        pend_d      = issue;
        pend_last_d = issue && last_addr;
        state_d     = state_q;
        len_d       = len_q;
        rev_d       = rev_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && blk_len != '0 && blk_len <= MAX_L) begin
                    state_d  = WRITE;
                    len_d    = blk_len;
                    rev_d    = rev;
                    wr_cnt_d = '0;
                    rd_cnt_d = '0;
                end else begin
                    err_d = start;
                end
            end
            WRITE: begin
                if (ram_we) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    state_d  = wr_cnt_q == len_q - 1'b1 ? READ : WRITE;
                end
            end
            READ: begin
                if (issue) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    state_d  = last_addr ? FLUSH : READ;
                end
            end
            default: begin
                if (m_valid_q && m_ready && m_last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            rev_q       <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            sk_valid_q  <= 1'b0;
            sk_data_q   <= '0;
            sk_last_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            rev_q       <= rev_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            sk_valid_q  <= sk_valid_d;
            sk_data_q   <= sk_data_d;
            sk_last_q   <= sk_last_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign busy    = state_q != IDLE;
    assign done    = done_q;
    assign err     = err_q;
endmodule

// File: tb/tb_siso_llr_buf_ctrl.sv
// tb_siso_llr_buf_ctrl: scoreboard bench for siso_llr_buf_ctrl with a behavioural RAM
module tb_siso_llr_buf_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [12:0] blk_len = '0;
    logic        rev = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_ready;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_last;
    logic        m_ready = 1'b1;
    logic        ram_we;
    logic [12:0] ram_addr;
    logic [15:0] ram_di;
    logic [15:0] ram_dout;
    logic        busy;
    logic        done;
    logic        err;

    siso_llr_buf_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .blk_len(blk_len), .rev(rev),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_dout(ram_dout),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:8191];
    always @(posedge clk) begin
        ram_dout <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_di;
    end

    int total = 0;
    int bad = 0;
    logic [16:0] exp_q [$];
    logic [15:0] dat [0:6146];
    int hs_cnt = 0;
    int wr_total = 0;
    int wr_base = 0;
    int err_cnt = 0;
    int cur_len = 1;
    int m_mode = 0;
    int pcnt = 0;
    logic [7:0] pat = 8'b11010010;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, expv, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        pcnt++;
        m_ready = m_mode == 0 ? 1'b1 : m_mode == 1 ? pat[3'(7 - pcnt % 8)] : 1'($urandom_range(0, 1));
    end

    logic        stall_p = 1'b0;
    logic [16:0] stall_v;
    logic [16:0] mon_e;
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) check("extra_sample", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                check("m_data", 32'(m_data), 32'(mon_e[15:0]));
                check("m_last", 32'(m_last), 32'(mon_e[16]));
            end
        end
        if (stall_p) begin
            check("stall_valid", 32'(m_valid), 1);
            check("stall_hold", 32'({m_last, m_data}), 32'(stall_v));
        end
        stall_p = m_valid && !m_ready && !rst;
        stall_v = {m_last, m_data};
        if (ram_we) begin
            check("wr_addr", 32'(ram_addr), 32'(wr_total - wr_base));
            wr_total++;
        end
        if (busy) check("addr_bound", 32'(int'(ram_addr) < cur_len), 1);
        if (err) err_cnt++;
    end

    task automatic chk_idle(input string nm);
        check({nm, "_ctl"}, 32'({s_ready, m_valid, m_last, ram_we, busy, done, err}), 0);
        check({nm, "_addr"}, 32'(ram_addr), 0);
        check({nm, "_data"}, {ram_di, m_data}, 0);
    endtask

    task automatic issue_start(input int len, input bit rv);
        @(posedge clk); #1;
        start = 1'b1; blk_len = 13'(len); rev = rv;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Fills the block, pushes the expected replay order, and streams the samples in.
    task automatic load_block(input int len, input bit rv, input int dpat, input bit gap, input bit xstart);
        int i = 0;
        int g = 0;
        for (int k = 0; k < len; k++)
            dat[k] = dpat == 0 ? 16'(16'h10 + k) : dpat == 1 ? 16'(k) : 16'($urandom);
        for (int k = 0; k < len; k++)
            exp_q.push_back({k == len - 1, dat[rv ? len - 1 - k : k]});
        cur_len = len;
        wr_base = wr_total;
        issue_start(len, rv);
        while (i < len && g < 4 * len + 100) begin
            s_valid = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data = dat[i];
            start = xstart && g == 2;
            blk_len = xstart && g == 2 ? 13'd3 : 13'(len);
            @(negedge clk);
            if (s_valid && s_ready) i++;
            g++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        start = 1'b0;
        if (i < len) check("write_timeout", 32'(i), 32'(len));
    endtask

    task automatic run_block(input int len, input bit rv, input int dpat, input bit gap,
                             input int mm, input bit full, input bit xstart);
        int cyc = 0;
        int hs0 = hs_cnt;
        int e0 = err_cnt;
        m_mode = mm;
        load_block(len, rv, dpat, gap, xstart);
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 6 * len + 60);
        check("done_seen", 32'(done), 1);
        if (full) check("latency", 32'(cyc), 32'(len + 3));
        check("busy_at_done", 32'(busy), 0);
        check("hs_count", 32'(hs_cnt - hs0), 32'(len));
        check("exp_empty", 32'(exp_q.size()), 0);
        check("writes", 32'(wr_total - wr_base), 32'(len));
        check("no_err", 32'(err_cnt - e0), 0);
        @(negedge clk);
        check("done_pulse", 32'(done), 0);
        m_mode = 0;
    endtask

    task automatic bad_start(input int len);
        int w0 = wr_total;
        issue_start(len, 1'b0);
        @(negedge clk);
        check("err_pulse", 32'(err), 1);
        check("err_busy", 32'(busy), 0);
        @(negedge clk);
        check("err_once", 32'(err), 0);
        check("err_busy2", 32'(busy), 0);
        check("err_no_write", 32'(wr_total - w0), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int g;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle("reset");

        run_block(8, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        run_block(6147, 1'b1, 1, 1'b0, 0, 1'b1, 1'b0);
        run_block(16, 1'b1, 2, 1'b0, 1, 1'b0, 1'b0);
        bad_start(0);
        bad_start(6148);
        run_block(4, 1'b0, 2, 1'b0, 0, 1'b1, 1'b0);
        run_block(5, 1'b0, 2, 1'b1, 0, 1'b0, 1'b1);
        run_block(1, 1'b1, 2, 1'b0, 0, 1'b1, 1'b0);

        hs0 = hs_cnt;
        g = 0;
        load_block(10, 1'b0, 2, 1'b0, 1'b0);
        while (hs_cnt - hs0 < 3 && g < 100) begin
            @(posedge clk);
            g++;
        end
        check("pre_reset_hs", 32'(hs_cnt - hs0 >= 3), 1);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_idle("mid_reset");
        exp_q.delete();
        run_block(4, 1'b1, 2, 1'b0, 0, 1'b1, 1'b0);

        for (int r = 0; r < 10; r++)
            run_block($urandom_range(1, 64), 1'($urandom_range(0, 1)), 2,
                      1'($urandom_range(0, 1)), 2, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
